spi_rx_frontend: RTL and testbench

//  SPI slave receive front end feeding the memory controller. Oversamples SCLK/MOSI/CS_N in the clk domain,

---
 rtl/spi_rx_frontend.sv | 181 ++++++++++++++++++
 tb/tb_spi_rx_frontend.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_frontend.sv
// SPI slave receive front end: oversamples SCLK/MOSI/CS_N, decodes the frame command byte into mode
// and deserialises NPU_DATA_WIDTH-bit words. Define SPI_RX_ERR_CNT_EN to add the err_count output.
`timescale 1ns/1ps

module spi_rx_frontend #(
    parameter int          NPU_DATA_WIDTH = 16,
    parameter int          SYNC_STAGES    = 2,
    parameter logic [7:0]  CMD_REG        = 8'hA0,
    parameter logic [7:0]  CMD_STREAM     = 8'hD0
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic                      sclk,
    input  logic                      mosi,
    input  logic                      cs_n,
    output logic [1:0]                mode,
    output logic [NPU_DATA_WIDTH-1:0] spi_data_out,
    output logic                      spi_wr_en,
    output logic                      frame_active
`ifdef SPI_RX_ERR_CNT_EN
    ,
    output logic [7:0]                err_count
`endif
);

    localparam int                CNT_W     = $clog2(NPU_DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(NPU_DATA_WIDTH - 1);
    localparam logic [1:0]        MODE_IDLE   = 2'b00;
    localparam logic [1:0]        MODE_REG    = 2'b10;
    localparam logic [1:0]        MODE_STREAM = 2'b01;

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        DATA,
        DROP
    } state_t;

    state_t                    r_state;
    logic [SYNC_STAGES-1:0]    r_sclk_sync;
    logic [SYNC_STAGES-1:0]    r_mosi_sync;
    logic [SYNC_STAGES-1:0]    r_cs_sync;
    logic                      r_sclk_d;
    logic [CNT_W-1:0]          r_bit_cnt;
    logic [NPU_DATA_WIDTH-1:0] r_shift;

    logic                      w_sclk;
    logic                      w_mosi;
    logic                      w_cs_hi;
    logic                      w_sclk_rise;
    logic [NPU_DATA_WIDTH-1:0] w_shift_next;
    logic [7:0]                w_cmd_byte;

    // NOTE: the cs_n chain resets to 0 so WAIT_CS only exits once a genuinely high cs_n has
    // propagated through the synchroniser, never on the reset value itself.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_hi      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise  = w_sclk & ~r_sclk_d;
    assign w_shift_next = {r_shift[NPU_DATA_WIDTH-2:0], w_mosi};
    assign w_cmd_byte   = w_shift_next[7:0];

    // NOTE: all state and outputs use non-blocking assignments; the cs_n-high override at the end
    // of the block deliberately wins over anything the case statement scheduled for the same regs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= WAIT_CS;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            mode         <= MODE_IDLE;
            spi_data_out <= '0;
            spi_wr_en    <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            spi_wr_en <= 1'b0;
            case (r_state)
                WAIT_CS: begin
                    if (w_cs_hi) r_state <= IDLE;
                end
                IDLE: begin
                    mode <= MODE_IDLE;
                    if (!w_cs_hi) begin
                        r_state   <= CMD;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        if (r_bit_cnt == CMD_LAST) begin
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                            if (w_cmd_byte == CMD_REG) begin
                                r_state      <= DATA;
                                mode         <= MODE_REG;
                                frame_active <= 1'b1;
                            end else if (w_cmd_byte == CMD_STREAM) begin
                                r_state      <= DATA;
                                mode         <= MODE_STREAM;
                                frame_active <= 1'b1;
                            end else begin
                                r_state <= DROP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_next;
                        end
                    end
                end
                DATA: begin
                    if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt    <= '0;
                            spi_data_out <= w_shift_next;
                            spi_wr_en    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                DROP: ;
                default: r_state <= WAIT_CS;
            endcase

            // Frame end: a word finishing on this same sample still reaches the outputs above.
            if (r_state != WAIT_CS && w_cs_hi) begin
                r_state      <= IDLE;
                r_bit_cnt    <= '0;
                r_shift      <= '0;
                mode         <= MODE_IDLE;
                frame_active <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_ERR_CNT_EN
    logic w_err_event;

    always_comb begin
        w_err_event = 1'b0;
        case (r_state)
            CMD: begin
                if (w_cs_hi)
                    w_err_event = (r_bit_cnt != '0);
                else if (w_sclk_rise && r_bit_cnt == CMD_LAST)
                    w_err_event = (w_cmd_byte != CMD_REG) && (w_cmd_byte != CMD_STREAM);
            end
            DATA: begin
                w_err_event = w_cs_hi && (r_bit_cnt != '0) &&
                              !(w_sclk_rise && r_bit_cnt == DATA_LAST);
            end
            default: w_err_event = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            err_count <= 8'h00;
        else if (w_err_event && err_count != 8'hFF)
            err_count <= err_count + 8'h01;
    end
`endif

endmodule

// File: tb/tb_spi_rx_frontend.sv
// Self-checking bench for spi_rx_frontend: table of frames plus hand-written reset and
// coincident-edge sequences; completed words are checked against a scoreboard queue.
`timescale 1ns/1ps

module tb_spi_rx_frontend;

    localparam int W  = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          sclk;
    logic          mosi;
    logic          cs_n;
    logic [1:0]    mode;
    logic [W-1:0]  spi_data_out;
    logic          spi_wr_en;
    logic          frame_active;
`ifdef SPI_RX_ERR_CNT_EN
    logic [7:0]    err_count;
    int            exp_err = 0;
`endif

    spi_rx_frontend #(
        .NPU_DATA_WIDTH(W),
        .SYNC_STAGES   (SS),
        .CMD_REG       (8'hA0),
        .CMD_STREAM    (8'hD0)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs_n         (cs_n),
        .mode         (mode),
        .spi_data_out (spi_data_out),
        .spi_wr_en    (spi_wr_en),
        .frame_active (frame_active)
`ifdef SPI_RX_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  last_word = '0;
    int            cyc = 0;
    int            last_pulse_cyc = -100000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every strobe must match the oldest pending word and be spaced >= 4*W clocks.
    always @(negedge clk) begin
        if (spi_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", spi_data_out, 32'hDEAD);
            end else begin
                check("wr_data", spi_data_out, exp_q.pop_front());
            end
            check("wr_spacing_ok", (cyc - last_pulse_cyc) >= 4 * W, 1);
            last_pulse_cyc = cyc;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // sclk runs at clk/8; all pin changes land on falling clk edges.
    task automatic spi_bit(input logic b);
        mosi = b;
        #40 sclk = 1'b1;
        #40 sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic end_frame();
        #40 cs_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        string        name;
        logic [7:0]   cmd;
        int           n_words;
        logic [W-1:0] words [3];
        int           tail_bits;
        logic [1:0]   exp_mode;
        int           exp_err_inc;
    } frame_t;

    task automatic check_after_frame(input string name);
        check({name, "_mode_end"},   mode, 2'b00);
        check({name, "_active_end"}, frame_active, 1'b0);
        check({name, "_pending"},    exp_q.size(), 0);
        check({name, "_data_held"},  spi_data_out, last_word);
`ifdef SPI_RX_ERR_CNT_EN
        check({name, "_err_count"},  err_count, exp_err);
`endif
    endtask

    task automatic run_frame(input frame_t f);
        cs_n = 1'b0;
        #40;
        send_bits({8'h00, f.cmd}, 8);
        #40;
        check({f.name, "_mode"},   mode, f.exp_mode);
        check({f.name, "_active"}, frame_active, f.exp_mode != 2'b00);
        for (int w = 0; w < f.n_words; w++) begin
            if (f.exp_mode != 2'b00) begin
                exp_q.push_back(f.words[w]);
                last_word = f.words[w];
            end
            send_bits(f.words[w], W);
        end
        if (f.tail_bits > 0) send_bits(f.words[f.n_words] >> (W - f.tail_bits), f.tail_bits);
        end_frame();
`ifdef SPI_RX_ERR_CNT_EN
        exp_err += f.exp_err_inc;
`endif
        check_after_frame(f.name);
    endtask

    frame_t vec [5];
    frame_t f;
    int     lat;

    initial begin
        vec[0] = '{"reg2",     8'hA0, 2, '{16'h0008, 16'h0003, 16'h0000}, 0, 2'b10, 0};
        vec[1] = '{"stream3",  8'hD0, 3, '{16'h1111, 16'h2222, 16'h3333}, 0, 2'b01, 0};
        vec[2] = '{"partial",  8'hA0, 0, '{16'hABCD, 16'h0000, 16'h0000}, 9, 2'b10, 1};
        vec[3] = '{"badcmd",   8'h5A, 1, '{16'h1234, 16'h0000, 16'h0000}, 0, 2'b00, 1};
        vec[4] = '{"beef",     8'hD0, 1, '{16'hBEEF, 16'h0000, 16'h0000}, 0, 2'b01, 0};

        reset_b = 1'b0;
        sclk    = 1'b0;
        mosi    = 1'b0;
        cs_n    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mode",   mode, 2'b00);
        check("rst_data",   spi_data_out, '0);
        check("rst_wr_en",  spi_wr_en, 1'b0);
        check("rst_active", frame_active, 1'b0);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(vec[i]);

        // Reset mid-word with cs_n held low: outputs clear at once, the rest of the frame is ignored.
        cs_n = 1'b0;
        #40;
        send_bits(16'h00A0, 8);
        send_bits(16'h0015, 5);
        reset_b = 1'b0;
        #1;
        check("midrst_mode",   mode, 2'b00);
        check("midrst_data",   spi_data_out, '0);
        check("midrst_wr_en",  spi_wr_en, 1'b0);
        check("midrst_active", frame_active, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        last_word = '0;
`ifdef SPI_RX_ERR_CNT_EN
        exp_err = 0;
`endif
        send_bits(16'h07FF, 11);
        send_bits(16'hA55A, 16);
        check("midrst_ignored_mode", mode, 2'b00);
        end_frame();
        check_after_frame("midrst");
        f = '{"after_rst", 8'hD0, 1, '{16'h5AA5, 16'h0000, 16'h0000}, 0, 2'b01, 0};
        run_frame(f);

        // Final sclk rise and cs_n rise hit the pins together: the word still completes once.
        cs_n = 1'b0;
        #40;
        send_bits(16'h00D0, 8);
        #40;
        exp_q.push_back(16'hC3A5);
        last_word = 16'hC3A5;
        send_bits(16'hC3A5 >> 1, 15);
        mosi = 1'b1;
        #40;
        sclk = 1'b1;
        cs_n = 1'b1;
        lat  = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (spi_wr_en) begin
                lat = k;
                break;
            end
        end
        check("coincide_latency_ok", (lat >= SS) && (lat <= SS + 2), 1);
        #40 sclk = 1'b0;
        repeat (20) @(negedge clk);
        check_after_frame("coincide");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
